mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_if.sv | 54 +++++
 rtl/mem_port_arbiter.sv | 88 ++++++++
 tb/tb_mem_port_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and downstream memory-port handshakes.
// master = requesters + memory side, slave = the arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                inst_req;
    logic                inst_wr;
    logic [1:0]          inst_size;
    logic [DATA_W/8-1:0] inst_wstrb;
    logic [ADDR_W-1:0]   inst_addr;
    logic [DATA_W-1:0]   inst_wdata;
    logic                inst_addr_ok;
    logic                inst_data_ok;
    logic [DATA_W-1:0]   inst_rdata;

    logic                data_req;
    logic                data_wr;
    logic [1:0]          data_size;
    logic [DATA_W/8-1:0] data_wstrb;
    logic [ADDR_W-1:0]   data_addr;
    logic [DATA_W-1:0]   data_wdata;
    logic                data_addr_ok;
    logic                data_data_ok;
    logic [DATA_W-1:0]   data_rdata;

    logic                mem_req;
    logic                mem_wr;
    logic [1:0]          mem_size;
    logic [DATA_W/8-1:0] mem_wstrb;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_addr_ok;
    logic                mem_data_ok;
    logic [DATA_W-1:0]   mem_rdata;

    modport slave (
        input  inst_req, inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );

    modport master (
        output inst_req, inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and data, one transaction in flight.
// Grant is same-cycle in IDLE, mem_req next cycle; stalled mem_addr_ok holds the latched payload.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);
    typedef struct packed {
        logic                wr;
        logic [1:0]          size;
        logic [DATA_W/8-1:0] wstrb;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   wdata;
    } payload_t;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t   state_q, state_d;
    payload_t pay_q, pay_d;
    logic     owner_q, owner_d;
    logic     last_owner_q, last_owner_d;
    logic     grant;
    logic     winner;
    logic     rsp;

    payload_t inst_pay, data_pay;
    assign inst_pay = '{bus.inst_wr, bus.inst_size, bus.inst_wstrb, bus.inst_addr, bus.inst_wdata};
    assign data_pay = '{bus.data_wr, bus.data_size, bus.data_wstrb, bus.data_addr, bus.data_wdata};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pay_q        <= '0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pay_q        <= pay_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pay_d        = pay_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        grant        = 1'b0;
        winner       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.inst_req || bus.data_req) begin
                    grant = 1'b1;
                    // On a tie the requester that did not win last time goes first.
                    winner       = (bus.inst_req && bus.data_req) ? ~last_owner_q : bus.data_req;
                    pay_d        = winner ? data_pay : inst_pay;
                    owner_d      = winner;
                    last_owner_d = winner;
                    state_d      = REQ;
                end
            end
            REQ:     if (bus.mem_addr_ok) state_d = WAIT;
            WAIT:    if (bus.mem_data_ok) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.inst_addr_ok = !reset && grant && !winner;
    assign bus.data_addr_ok = !reset && grant && winner;

    // mem_data_ok is only meaningful once the request has been accepted.
    assign rsp              = !reset && (state_q == WAIT) && bus.mem_data_ok;
    assign bus.inst_data_ok = rsp && !owner_q;
    assign bus.data_data_ok = rsp && owner_q;
    assign bus.inst_rdata   = bus.mem_rdata;
    assign bus.data_rdata   = bus.mem_rdata;

    assign bus.mem_req   = !reset && (state_q == REQ);
    assign bus.mem_wr    = pay_q.wr;
    assign bus.mem_size  = pay_q.size;
    assign bus.mem_wstrb = pay_q.wstrb;
    assign bus.mem_addr  = pay_q.addr;
    assign bus.mem_wdata = pay_q.wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level model checked every cycle
// plus hand-computed expectations at key points of each scenario.
module tb_mem_port_arbiter;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    bit   pending;       // a transaction has been granted and not yet answered
    bit   accepted;      // the memory has taken its request
    bit   pend_is_data;
    bit   prev_was_data; // who won the previous arbitration
    txn_t pend;

    always @(negedge clk) begin
        bit   want_i, want_d, who;
        bit   e_iaok, e_daok, e_idok, e_ddok, e_mreq;
        want_i = bus.inst_req;
        want_d = bus.data_req;
        who    = (want_i && want_d) ? !prev_was_data : want_d;
        e_iaok = !reset && !pending && (want_i || want_d) && !who;
        e_daok = !reset && !pending && (want_i || want_d) && who;
        e_mreq = !reset && pending && !accepted;
        e_idok = !reset && pending && accepted && bus.mem_data_ok && !pend_is_data;
        e_ddok = !reset && pending && accepted && bus.mem_data_ok && pend_is_data;

        chk("inst_addr_ok", bus.inst_addr_ok, e_iaok);
        chk("data_addr_ok", bus.data_addr_ok, e_daok);
        chk("inst_data_ok", bus.inst_data_ok, e_idok);
        chk("data_data_ok", bus.data_data_ok, e_ddok);
        chk("mem_req", bus.mem_req, e_mreq);
        chk("inst_rdata", bus.inst_rdata, bus.mem_rdata);
        chk("data_rdata", bus.data_rdata, bus.mem_rdata);
        if (e_mreq) begin
            chk("mem_wr", bus.mem_wr, pend.wr);
            chk("mem_size", bus.mem_size, pend.size);
            chk("mem_wstrb", bus.mem_wstrb, pend.wstrb);
            chk("mem_addr", bus.mem_addr, pend.addr);
            chk("mem_wdata", bus.mem_wdata, pend.wdata);
        end

        if (reset) begin
            pending       = 0;
            accepted      = 0;
            prev_was_data = 0;
            pend          = '0;
        end else if (!pending) begin
            if (want_i || want_d) begin
                pending       = 1;
                accepted      = 0;
                pend_is_data  = who;
                prev_was_data = who;
                pend = who ? '{bus.data_wr, bus.data_size, bus.data_wstrb, bus.data_addr, bus.data_wdata}
                           : '{bus.inst_wr, bus.inst_size, bus.inst_wstrb, bus.inst_addr, bus.inst_wdata};
            end
        end else if (!accepted) begin
            if (bus.mem_addr_ok) accepted = 1;
        end else if (bus.mem_data_ok) begin
            pending  = 0;
            accepted = 0;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b0;
    endtask

    // REQ cycle accepted immediately, then the response in the WAIT cycle.
    task automatic serve(input logic [31:0] rd);
        step();
        bus.mem_addr_ok = 1'b1;
        step();
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = rd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b1;
        bus.inst_req = 0; bus.inst_wr = 0; bus.inst_size = 0; bus.inst_wstrb = 0;
        bus.inst_addr = 0; bus.inst_wdata = 0;
        bus.data_req = 0; bus.data_wr = 0; bus.data_size = 0; bus.data_wstrb = 0;
        bus.data_addr = 0; bus.data_wdata = 0;
        bus.mem_addr_ok = 0; bus.mem_data_ok = 0; bus.mem_rdata = 0;

        step(); step();
        #2;
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wstrb", bus.mem_wstrb, 4'h0);
        step();
        reset = 1'b0;

        // Single fetch
        step();
        bus.inst_req = 1; bus.inst_addr = 32'h1C00_0000; bus.inst_size = 2;
        #2 chk("fetch_aok", bus.inst_addr_ok, 1'b1);
        step();
        bus.inst_req = 0; bus.mem_addr_ok = 1;
        #2 chk("fetch_mreq", bus.mem_req, 1'b1);
        chk("fetch_maddr", bus.mem_addr, 32'h1C00_0000);
        step();
        bus.mem_data_ok = 1; bus.mem_rdata = 32'h0280_0C0C;
        #2 chk("fetch_dok", bus.inst_data_ok, 1'b1);
        chk("fetch_rdata", bus.inst_rdata, 32'h0280_0C0C);
        chk("fetch_ddok", bus.data_data_ok, 1'b0);

        // Ties alternate: data, inst, data
        step();
        bus.inst_req = 1; bus.data_req = 1;
        #2 chk("tie1_data", bus.data_addr_ok, 1'b1);
        serve(32'h1111_1111);
        step();
        #2 chk("tie2_inst", bus.inst_addr_ok, 1'b1);
        serve(32'h2222_2222);
        step();
        #2 chk("tie3_data", bus.data_addr_ok, 1'b1);
        serve(32'h3333_3333);

        // Byte store under downstream backpressure
        step();
        bus.inst_req = 0; bus.data_req = 1; bus.data_wr = 1; bus.data_size = 0;
        bus.data_wstrb = 4'b0100; bus.data_addr = 32'h8; bus.data_wdata = 32'h00AB_0000;
        #2 chk("st_aok", bus.data_addr_ok, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            bus.data_addr  = 32'h100 * (i + 1);
            bus.data_wdata = ~bus.data_wdata;
            bus.data_wstrb = bus.data_wstrb + 4'd1;
            bus.data_wr    = i[0];
            bus.mem_data_ok = (i == 2);
            #2 chk("st_hold_req", bus.mem_req, 1'b1);
            chk("st_hold_addr", bus.mem_addr, 32'h8);
            chk("st_hold_wdata", bus.mem_wdata, 32'h00AB_0000);
            chk("st_hold_wstrb", bus.mem_wstrb, 4'b0100);
            chk("st_hold_wr", bus.mem_wr, 1'b1);
            chk("st_hold_ddok", bus.data_data_ok, 1'b0);
        end
        serve(32'h4444_4444);

        // No starvation: data keeps asking, inst joins
        step();
        bus.data_wr = 0; bus.data_addr = 32'h40;
        #2 chk("ns_data", bus.data_addr_ok, 1'b1);
        serve(32'h5555_5555);
        step();
        bus.inst_req = 1; bus.inst_addr = 32'h1C00_0004;
        #2 chk("ns_inst", bus.inst_addr_ok, 1'b1);
        serve(32'h6666_6666);

        // Reset while waiting for the response
        step();
        bus.inst_req = 0;
        #2 chk("rw_grant", bus.data_addr_ok, 1'b1);
        step();
        bus.data_req = 0; bus.mem_addr_ok = 1;
        step();
        reset = 1;
        #2 chk("rw_ddok", bus.data_data_ok, 1'b0);
        chk("rw_mreq", bus.mem_req, 1'b0);
        step();
        reset = 0; bus.mem_data_ok = 1; bus.mem_rdata = 32'hDEAD_BEEF;
        #2 chk("rw_late_ddok", bus.data_data_ok, 1'b0);
        chk("rw_late_idok", bus.inst_data_ok, 1'b0);
        step();
        bus.inst_req = 1; bus.data_req = 1;
        #2 chk("rw_tie_data", bus.data_addr_ok, 1'b1);
        serve(32'h7777_7777);

        // Spurious memory handshakes in IDLE
        step();
        bus.inst_req = 0; bus.data_req = 0; bus.mem_addr_ok = 1; bus.mem_data_ok = 1;
        #2 chk("sp_idle_idok", bus.inst_data_ok, 1'b0);
        chk("sp_idle_ddok", bus.data_data_ok, 1'b0);
        step();
        #2 chk("sp_idle_mreq", bus.mem_req, 1'b0);

        // Response in the same cycle as acceptance is ignored
        step();
        bus.inst_req = 1; bus.inst_addr = 32'h1C00_0008;
        step();
        bus.inst_req = 0; bus.mem_addr_ok = 1; bus.mem_data_ok = 1;
        #2 chk("same_cyc_idok", bus.inst_data_ok, 1'b0);
        step();
        #2 chk("same_cyc_wait", bus.inst_data_ok, 1'b0);
        step();
        bus.mem_data_ok = 1; bus.mem_rdata = 32'h8888_8888;
        #2 chk("same_cyc_dok", bus.inst_data_ok, 1'b1);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
